// File: rtl/poly_bank_io.sv
// poly_bank_io: host loader/unloader for the two-bank coefficient memory.
// Coefficient i lives in bank i[0] at address {region, i[7:1]}.
//
// state  | meaning
// IDLE   | waiting for start_load / start_unload
// LOAD   | accepting input beats, one bank write per accepted beat
// UNLOAD | issuing bank reads, streaming results out in natural order
// FIN    | one-cycle done pulse, then back to IDLE
//
// The output FIFO is fall-through: a word arriving from the banks is visible
// at the head in the same cycle when the FIFO is empty. This keeps the
// issue-to-pop loop at two cycles, so two credits sustain one beat per cycle.
module poly_bank_io #(
  parameter int DATA_W = 12,
  parameter int N      = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_load,
  input  logic              start_unload,
  input  logic              region,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [7:0]        mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen0,
  output logic              mem_wen1,
  output logic [7:0]        mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata0,
  input  logic [DATA_W-1:0] mem_rdata1
);

  typedef enum logic [1:0] {IDLE, LOAD, UNLOAD, FIN} state_t;

  localparam logic [8:0] TERM = 9'(N);
  localparam logic [8:0] LAST = TERM - 9'd1;

  state_t            state;
  logic              region_q;
  logic [8:0]        cnt;
  logic [8:0]        ocnt;
  logic [RD_LAT:0]   pv;
  logic [RD_LAT:0]   ps;
  logic [DATA_W-1:0] f_data [2];
  logic [1:0]        f_cnt;

  logic              accept;
  logic              arrive;
  logic [DATA_W-1:0] bus_data;
  logic              pop;
  logic              pop_fifo;
  logic              push;
  logic              widx;
  logic [3:0]        in_flight;
  logic [3:0]        level;
  logic              issue;

  assign busy     = (state == LOAD) || (state == UNLOAD);
  assign done     = (state == FIN);
  assign s_ready  = (state == LOAD) && (cnt != TERM);
  assign accept   = s_valid && s_ready;
  assign arrive   = (state == UNLOAD) && pv[RD_LAT];
  assign bus_data = ps[RD_LAT] ? mem_rdata1 : mem_rdata0;
  assign m_valid  = (state == UNLOAD) && ((f_cnt != 2'd0) || arrive);
  assign m_data   = (f_cnt != 2'd0) ? f_data[0] : (arrive ? bus_data : '0);
  assign pop      = m_valid && m_ready;
  assign pop_fifo = pop && (f_cnt != 2'd0);
  assign push     = arrive && !(pop && (f_cnt == 2'd0));
  assign widx     = (f_cnt == 2'd1) && !pop_fifo;

  // Read credit: reads still in the bank pipeline plus words held or arriving,
  // less the word leaving this cycle, must stay below the FIFO depth.
  always_comb begin
    in_flight = '0;
    for (int k = 0; k < RD_LAT; k++) in_flight = in_flight + 4'(pv[k]);
    level = in_flight + 4'(f_cnt) + 4'(arrive) - 4'(pop);
    issue = (state == UNLOAD) && (cnt != TERM) && (level < 4'd2);
  end

  // Sequencer state, counters, write/read ports and output FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      region_q  <= 1'b0;
      cnt       <= '0;
      ocnt      <= '0;
      pv        <= '0;
      ps        <= '0;
      f_data[0] <= '0;
      f_data[1] <= '0;
      f_cnt     <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_wen0  <= 1'b0;
      mem_wen1  <= 1'b0;
      mem_raddr <= '0;
    end else begin
      mem_wen0 <= 1'b0;
      mem_wen1 <= 1'b0;
      pv       <= {pv[RD_LAT-1:0], issue};
      ps       <= {ps[RD_LAT-1:0], cnt[0]};
      if (pop_fifo) f_data[0] <= f_data[1];
      if (push) f_data[widx] <= bus_data;
      f_cnt <= f_cnt - {1'b0, pop_fifo} + {1'b0, push};

      case (state)
        IDLE: begin
          if (start_load) begin
            state    <= LOAD;
            region_q <= region;
            cnt      <= '0;
          end else if (start_unload) begin
            state    <= UNLOAD;
            region_q <= region;
            cnt      <= '0;
            ocnt     <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            mem_waddr <= {region_q, cnt[7:1]};
            mem_wdata <= s_data;
            mem_wen0  <= ~cnt[0];
            mem_wen1  <= cnt[0];
            cnt       <= cnt + 9'd1;
            if (cnt == LAST) state <= FIN;
          end
        end
        UNLOAD: begin
          if (issue) begin
            mem_raddr <= {region_q, cnt[7:1]};
            cnt       <= cnt + 9'd1;
          end
          if (pop) begin
            ocnt <= ocnt + 9'd1;
            if (ocnt == LAST) begin
              state     <= FIN;
              mem_raddr <= '0;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
